// File: rtl/datamem_axi_slave.sv
// rtl/datamem_axi_slave.sv - AXI4 slave backed by word-addressed on-chip RAM
// Independent read/write FSMs, one outstanding transaction per direction.
module datamem_axi_slave #(
  parameter int C_S_AXI_ID_WIDTH     = 1,
  parameter int C_S_AXI_ADDR_WIDTH   = 32,
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int C_S_AXI_BUSER_WIDTH  = 1,
  parameter int C_S_AXI_RUSER_WIDTH  = 4,
  parameter int C_S_AXI_AWUSER_WIDTH = 1,
  parameter int C_S_AXI_WUSER_WIDTH  = 1,
  parameter int C_S_AXI_ARUSER_WIDTH = 1,
  parameter int MEM_ADDR_WIDTH       = 10
) (
  input  logic                              CLK,
  input  logic                              RSTN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [7:0]                        S_AXI_AWLEN,
  input  logic [2:0]                        S_AXI_AWSIZE,
  input  logic [1:0]                        S_AXI_AWBURST,
  input  logic                              S_AXI_AWLOCK,
  input  logic [3:0]                        S_AXI_AWCACHE,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic [3:0]                        S_AXI_AWQOS,
  input  logic [C_S_AXI_AWUSER_WIDTH-1:0]   S_AXI_AWUSER,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WLAST,
  input  logic [C_S_AXI_WUSER_WIDTH-1:0]    S_AXI_WUSER,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_BID,
  output logic [1:0]                        S_AXI_BRESP,
  output logic [C_S_AXI_BUSER_WIDTH-1:0]    S_AXI_BUSER,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [7:0]                        S_AXI_ARLEN,
  input  logic [2:0]                        S_AXI_ARSIZE,
  input  logic [1:0]                        S_AXI_ARBURST,
  input  logic                              S_AXI_ARLOCK,
  input  logic [3:0]                        S_AXI_ARCACHE,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic [3:0]                        S_AXI_ARQOS,
  input  logic [C_S_AXI_ARUSER_WIDTH-1:0]   S_AXI_ARUSER,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RLAST,
  output logic [C_S_AXI_RUSER_WIDTH-1:0]    S_AXI_RUSER,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY
);

  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;
  localparam logic [AW-1:0] ADDR_STEP = AW'(4);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [31:0] r_mem [0:DEPTH-1];

  w_state_t                    r_wstate;
  logic [C_S_AXI_ID_WIDTH-1:0] r_wid;
  logic [AW-1:0]               r_waddr;
  logic [1:0]                  r_wburst;
  logic                        r_werr;
  logic                        r_awready;
  logic                        r_wready;
  logic                        r_bvalid;
  logic [1:0]                  r_bresp;

  r_state_t                    r_rstate;
  logic [C_S_AXI_ID_WIDTH-1:0] r_rid;
  logic [AW-1:0]               r_raddr;
  logic [7:0]                  r_rlen;
  logic [1:0]                  r_rburst;
  logic [7:0]                  r_rcnt;
  logic                        r_arready;
  logic                        r_rvalid;
  logic                        r_rlast;
  logic [31:0]                 r_rdata;
  logic [1:0]                  r_rresp;

  logic                        w_w_in_range;
  logic                        w_mem_we;
  logic [AW-1:0]               w_wnext;
  logic                        w_ar_in_range;
  logic [AW-1:0]               w_rnext;
  logic                        w_rnext_in_range;
  logic                        w_unused_ok;

  // Range test: every address bit above the RAM span must be zero.
  assign w_w_in_range     = (r_waddr[AW-1:MEM_ADDR_WIDTH+2] == '0);
  assign w_ar_in_range    = (S_AXI_ARADDR[AW-1:MEM_ADDR_WIDTH+2] == '0);
  assign w_rnext          = r_raddr + ((r_rburst == 2'b00) ? '0 : ADDR_STEP);
  assign w_rnext_in_range = (w_rnext[AW-1:MEM_ADDR_WIDTH+2] == '0);
  assign w_wnext          = r_waddr + ((r_wburst == 2'b00) ? '0 : ADDR_STEP);
  assign w_mem_we         = r_wready && S_AXI_WVALID && w_w_in_range;

  assign w_unused_ok = ^{S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWLOCK, S_AXI_AWCACHE,
                         S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWUSER, S_AXI_WUSER,
                         S_AXI_ARSIZE, S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT,
                         S_AXI_ARQOS, S_AXI_ARUSER};

  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (S_AXI_WSTRB[i]) r_mem[r_waddr[MEM_ADDR_WIDTH+1:2]][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_wstate  <= W_IDLE;
      r_wid     <= '0;
      r_waddr   <= '0;
      r_wburst  <= 2'b00;
      r_werr    <= 1'b0;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: if (S_AXI_AWVALID) begin
          r_wid     <= S_AXI_AWID;
          r_waddr   <= S_AXI_AWADDR;
          r_wburst  <= S_AXI_AWBURST;
          r_werr    <= 1'b0;
          r_awready <= 1'b0;
          r_wready  <= 1'b1;
          r_wstate  <= W_DATA;
        end
        W_DATA: if (S_AXI_WVALID) begin
          if (!w_w_in_range) r_werr <= 1'b1;
          r_waddr <= w_wnext;
          if (S_AXI_WLAST) begin
            r_wready <= 1'b0;
            r_bvalid <= 1'b1;
            r_bresp  <= (r_werr || !w_w_in_range) ? RESP_SLVERR : RESP_OKAY;
            r_wstate <= W_RESP;
          end
        end
        W_RESP: if (S_AXI_BREADY) begin
          r_bvalid  <= 1'b0;
          r_awready <= 1'b1;
          r_wstate  <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // RAM is sampled at the load edge, so a same-edge write is not visible yet.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_rstate  <= R_IDLE;
      r_rid     <= '0;
      r_raddr   <= '0;
      r_rlen    <= 8'd0;
      r_rburst  <= 2'b00;
      r_rcnt    <= 8'd0;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rdata   <= 32'd0;
      r_rresp   <= RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: if (S_AXI_ARVALID) begin
          r_rid     <= S_AXI_ARID;
          r_raddr   <= S_AXI_ARADDR;
          r_rlen    <= S_AXI_ARLEN;
          r_rburst  <= S_AXI_ARBURST;
          r_rcnt    <= 8'd0;
          r_rdata   <= w_ar_in_range ? r_mem[S_AXI_ARADDR[MEM_ADDR_WIDTH+1:2]] : 32'd0;
          r_rresp   <= w_ar_in_range ? RESP_OKAY : RESP_SLVERR;
          r_rlast   <= (S_AXI_ARLEN == 8'd0);
          r_rvalid  <= 1'b1;
          r_arready <= 1'b0;
          r_rstate  <= R_DATA;
        end
        R_DATA: if (S_AXI_RREADY) begin
          if (r_rlast) begin
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rdata   <= 32'd0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end else begin
            r_rcnt  <= r_rcnt + 8'd1;
            r_raddr <= w_rnext;
            r_rdata <= w_rnext_in_range ? r_mem[w_rnext[MEM_ADDR_WIDTH+1:2]] : 32'd0;
            r_rresp <= w_rnext_in_range ? RESP_OKAY : RESP_SLVERR;
            r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BID     = r_wid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_BUSER   = '0;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RID     = r_rid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RLAST   = r_rlast;
  assign S_AXI_RUSER   = '0;
  assign S_AXI_RVALID  = r_rvalid;

endmodule

// File: tb/tb_datamem_axi_slave.sv
// tb/tb_datamem_axi_slave.sv - self-checking bench for datamem_axi_slave
// Directed steps plus randomized bursts checked against a byte-level RAM model.
module tb_datamem_axi_slave;

  logic        clk;
  logic        rstn;
  logic [0:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic [3:0]  awqos;
  logic [0:0]  awuser;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic [0:0]  wuser;
  logic        wvalid;
  logic        wready;
  logic [0:0]  bid;
  logic [1:0]  bresp;
  logic [0:0]  buser;
  logic        bvalid;
  logic        bready;
  logic [0:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [3:0]  arqos;
  logic [0:0]  aruser;
  logic        arvalid;
  logic        arready;
  logic [0:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  ruser;
  logic        rvalid;
  logic        rready;

  datamem_axi_slave dut (
    .CLK(clk), .RSTN(rstn),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
    .S_AXI_AWBURST(awburst), .S_AXI_AWLOCK(awlock), .S_AXI_AWCACHE(awcache), .S_AXI_AWPROT(awprot),
    .S_AXI_AWQOS(awqos), .S_AXI_AWUSER(awuser), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WUSER(wuser),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BUSER(buser), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
    .S_AXI_ARBURST(arburst), .S_AXI_ARLOCK(arlock), .S_AXI_ARCACHE(arcache), .S_AXI_ARPROT(arprot),
    .S_AXI_ARQOS(arqos), .S_AXI_ARUSER(aruser), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast), .S_AXI_RUSER(ruser),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  int checks = 0;
  int failures = 0;

  // Reference RAM: 1024 words, with a per-byte "known" mask for never-written bytes.
  logic [31:0] mdl [0:1023];
  logic [3:0]  kb  [0:1023];
  logic [31:0] wq_data [$];
  logic [3:0]  wq_strb [$];
  int          bready_delay = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [1:0] burst, input int i);
    return (burst == 2'b00) ? base : base + 32'(4 * i);
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [1:0] burst, input logic id, input bit gaps);
    int n;
    int t;
    logic [1:0]  exp_resp;
    logic [31:0] a;
    n = wq_data.size();
    exp_resp = 2'b00;
    @(negedge clk);
    awvalid = 1'b1; awaddr = addr; awburst = burst; awlen = 8'(n - 1); awid = id;
    t = 0;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    check("aw_wait", 32'(t < 50), 32'd1);
    @(negedge clk);
    awvalid = 1'b0; awaddr = $urandom;
    check("wready_after_aw", 32'(wready), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin wvalid = 1'b0; @(negedge clk); end
      wvalid = 1'b1; wdata = wq_data[i]; wstrb = wq_strb[i]; wlast = (i == n - 1);
      if (beat_addr(addr, burst, i) >= 32'h1000) exp_resp = 2'b10;
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("bvalid_after_wlast", 32'(bvalid), 32'd1);
    for (int k = 0; k < bready_delay; k++) begin
      check("bvalid_hold", 32'(bvalid), 32'd1);
      check("bid_hold", 32'(bid), 32'(id));
      check("awready_busy", 32'(awready), 32'd0);
      @(negedge clk);
    end
    check("bresp", 32'(bresp), 32'(exp_resp));
    check("bid", 32'(bid), 32'(id));
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("bvalid_drop", 32'(bvalid), 32'd0);
    check("awready_after_b", 32'(awready), 32'd1);
    for (int i = 0; i < n; i++) begin
      a = beat_addr(addr, burst, i);
      if (a < 32'h1000) begin
        for (int j = 0; j < 4; j++) begin
          if (wq_strb[i][j]) begin
            mdl[a[11:2]][8*j +: 8] = wq_data[i][8*j +: 8];
            kb[a[11:2]][j] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic id, input bit stall, output logic [31:0] d0);
    int t;
    int s;
    logic [31:0] a;
    logic [31:0] m;
    logic [31:0] ed;
    logic [1:0]  er;
    d0 = 32'd0;
    @(negedge clk);
    arvalid = 1'b1; araddr = addr; arlen = len; arburst = burst; arid = id;
    t = 0;
    while (!arready && t < 50) begin @(negedge clk); t++; end
    check("ar_wait", 32'(t < 50), 32'd1);
    @(negedge clk);
    arvalid = 1'b0; araddr = $urandom;
    check("rvalid_after_ar", 32'(rvalid), 32'd1);
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, burst, i);
      if (a < 32'h1000) begin m = byte_mask(kb[a[11:2]]); ed = mdl[a[11:2]] & m; er = 2'b00; end
      else begin m = 32'hFFFF_FFFF; ed = 32'd0; er = 2'b10; end
      s = 0;
      while (stall && s < 4 && $urandom_range(0, 2) == 0) begin
        rready = 1'b0;
        @(negedge clk);
        check("rvalid_stall", 32'(rvalid), 32'd1);
        check("rdata_stall", rdata & m, ed);
        check("rlast_stall", 32'(rlast), 32'(i == int'(len)));
        s++;
      end
      rready = 1'b1;
      check("rvalid", 32'(rvalid), 32'd1);
      check("rdata", rdata & m, ed);
      check("rresp", 32'(rresp), 32'(er));
      check("rlast", 32'(rlast), 32'(i == int'(len)));
      check("rid", 32'(rid), 32'(id));
      if (i == 0) d0 = rdata;
      @(negedge clk);
    end
    rready = 1'b0;
    check("rvalid_end", 32'(rvalid), 32'd0);
    check("rlast_end", 32'(rlast), 32'd0);
    check("rdata_end", rdata, 32'd0);
    check("arready_after_r", 32'(arready), 32'd1);
  endtask

  logic [31:0] d0;
  logic [31:0] d1;

  initial begin
    for (int i = 0; i < 1024; i++) begin mdl[i] = 32'd0; kb[i] = 4'd0; end
    rstn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awlock = 1'b0;
    awcache = '0; awprot = '0; awqos = '0; awuser = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wuser = '0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arlock = 1'b0;
    arcache = '0; arprot = '0; arqos = '0; aruser = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    check("rst_awready", 32'(awready), 32'd1);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rlast", 32'(rlast), 32'd0);
    check("rst_bresp", 32'(bresp), 32'd0);
    check("rst_rresp", 32'(rresp), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_bid", 32'(bid), 32'd0);
    check("rst_rid", 32'(rid), 32'd0);

    // Single write then read
    wq_data = '{32'hDEADBEEF}; wq_strb = '{4'hF};
    do_write(32'h10, 2'b01, 1'b1, 1'b0);
    do_read(32'h10, 8'd0, 2'b01, 1'b1, 1'b0, d0);
    check("single_rd", d0, 32'hDEADBEEF);

    // Byte strobes
    wq_data = '{32'h11223344}; wq_strb = '{4'hF};
    do_write(32'h20, 2'b01, 1'b0, 1'b0);
    wq_data = '{32'hAABBCCDD}; wq_strb = '{4'b0101};
    do_write(32'h20, 2'b01, 1'b0, 1'b0);
    do_read(32'h20, 8'd0, 2'b01, 1'b0, 1'b0, d0);
    check("strobe_rd", d0, 32'h11BB33DD);

    // INCR burst, then read back without and with stalls
    wq_data = '{32'd1, 32'd2, 32'd3, 32'd4}; wq_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
    do_write(32'h40, 2'b01, 1'b1, 1'b0);
    do_read(32'h40, 8'd3, 2'b01, 1'b1, 1'b0, d0);
    check("burst_rd0", d0, 32'd1);
    do_read(32'h40, 8'd3, 2'b01, 1'b0, 1'b1, d0);

    // Out of range
    wq_data = '{32'hCAFEF00D}; wq_strb = '{4'hF};
    do_write(32'h0, 2'b01, 1'b0, 1'b0);
    wq_data = '{32'h12345678}; wq_strb = '{4'hF};
    do_write(32'hFFC, 2'b01, 1'b0, 1'b0);
    wq_data = '{32'h0BADBAD0}; wq_strb = '{4'hF};
    do_write(32'h1000, 2'b01, 1'b1, 1'b0);
    do_read(32'h0, 8'd0, 2'b01, 1'b0, 1'b0, d0);
    check("oor_word0_kept", d0, 32'hCAFEF00D);
    do_read(32'hFFC, 8'd1, 2'b01, 1'b1, 1'b0, d0);
    check("oor_beat0", d0, 32'h12345678);

    // FIXED burst: all beats land on one word, last one wins
    wq_data = '{32'hA1, 32'hB2, 32'hC3}; wq_strb = '{4'hF, 4'hF, 4'hF};
    do_write(32'h100, 2'b00, 1'b0, 1'b0);
    do_read(32'h100, 8'd2, 2'b00, 1'b0, 1'b0, d0);
    check("fixed_rd", d0, 32'hC3);

    // Concurrent AR and AW to the same word, BREADY held off
    wq_data = '{32'h5}; wq_strb = '{4'hF};
    do_write(32'h80, 2'b01, 1'b0, 1'b0);
    wq_data = '{32'h9}; wq_strb = '{4'hF};
    bready_delay = 5;
    fork
      do_write(32'h80, 2'b01, 1'b1, 1'b0);
      do_read(32'h80, 8'd0, 2'b01, 1'b0, 1'b0, d1);
    join
    bready_delay = 0;
    check("concur_old", d1, 32'h5);
    do_read(32'h80, 8'd0, 2'b01, 1'b0, 1'b0, d0);
    check("concur_new", d0, 32'h9);

    // Randomized bursts
    for (int it = 0; it < 15; it++) begin
      logic [31:0] ra;
      logic [1:0]  rb;
      int          rl;
      logic        ri;
      ra = 32'($urandom_range(0, 1023) * 4);
      rb = 2'($urandom_range(0, 3));
      rl = $urandom_range(0, 7);
      ri = 1'($urandom_range(0, 1));
      wq_data.delete(); wq_strb.delete();
      for (int b = 0; b <= rl; b++) begin
        wq_data.push_back($urandom);
        wq_strb.push_back(4'($urandom_range(0, 15)));
      end
      do_write(ra, rb, ri, 1'b1);
      do_read(ra, 8'(rl), rb, ~ri, 1'b1, d0);
    end

    // Reset in the middle of a 4-beat read
    @(negedge clk);
    rready = 1'b1;
    arvalid = 1'b1; araddr = 32'h40; arlen = 8'd3; arburst = 2'b01; arid = 1'b0;
    @(negedge clk);
    arvalid = 1'b0;
    check("mid_rvalid_b0", 32'(rvalid), 32'd1);
    @(negedge clk);
    check("mid_rdata_b1", rdata, 32'd2);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_rlast", 32'(rlast), 32'd0);
    check("mid_rst_arready", 32'(arready), 32'd1);
    rready = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("mid_post_arready", 32'(arready), 32'd1);
    check("mid_post_rvalid", 32'(rvalid), 32'd0);
    do_read(32'h40, 8'd3, 2'b01, 1'b1, 1'b0, d0);
    check("mid_reread", d0, 32'd1);
    do_read(32'h20, 8'd0, 2'b01, 1'b0, 1'b0, d0);
    check("mid_reread_strobe", d0, 32'h11BB33DD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
